// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, fetch FSM and IF/ID register with one-entry skid
// Optional bubble counter output enabled by `define PC_FETCH_BUBBLE_CNT_EN
module pc_fetch_stage #(
  parameter logic [7:0]         PC_RESET  = 8'h00,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         pc_next_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               imem_req_o,
  output logic [7:0]         imem_addr_o,
  output logic [7:0]         pc_o,
  output logic [7:0]         pc_plus1_o,
  output logic               if_id_valid_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [7:0]         if_id_pc_o
`ifdef PC_FETCH_BUBBLE_CNT_EN
  ,
  output logic [7:0]         bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         ifpc_q, ifpc_d;
  logic [INSTR_W-1:0] skid_q, skid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RESET;
      vld_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 8'h00;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    skid_d  = skid_q;
    // A flush overrides stall and memory handshake in every state
    if (flush_i) begin
      state_d = ST_FETCH;
      pc_d    = pc_next_i;
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
      ifpc_d  = 8'h00;
      skid_d  = NOP_INSTR;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready_i && !stall_i) begin
            vld_d   = 1'b1;
            instr_d = imem_rdata_i;
            ifpc_d  = pc_q;
            pc_d    = pc_next_i;
          end else if (imem_ready_i) begin
            skid_d  = imem_rdata_i;
            state_d = ST_HOLD;
          end else if (!stall_i) begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            vld_d   = 1'b1;
            instr_d = skid_q;
            ifpc_d  = pc_q;
            pc_d    = pc_next_i;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  assign imem_req_o    = (state_q == ST_FETCH);
  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign pc_plus1_o    = pc_q + 8'd1;
  assign if_id_valid_o = vld_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = ifpc_q;

`ifdef PC_FETCH_BUBBLE_CNT_EN
  logic       bubble_load;
  logic [7:0] bubble_cnt_q;

  // Counts explicit invalid loads (flush or wait-state bubble), not holds
  assign bubble_load = flush_i ||
                       ((state_q == ST_FETCH) && !imem_ready_i && !stall_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= 8'h00;
    end else if (bubble_load && (bubble_cnt_q != 8'hFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 8'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - self-checking bench for pc_fetch_stage
// Optional bubble counter checked when PC_FETCH_BUBBLE_CNT_EN is defined
module tb_pc_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_next_i;
  logic        flush_i, stall_i, imem_ready_i;
  logic [15:0] imem_rdata_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o, pc_o, pc_plus1_o, if_id_pc_o;
  logic        if_id_valid_o;
  logic [15:0] if_id_instr_o;
`ifdef PC_FETCH_BUBBLE_CNT_EN
  logic [7:0]  bubble_cnt_o;
`endif

  logic        follow;
  logic [7:0]  pc_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = 16'hA000 + {8'h00, imem_addr_o};
  assign pc_next_i    = follow ? pc_plus1_o : pc_ovr;

  pc_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next_i     (pc_next_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .pc_o          (pc_o),
    .pc_plus1_o    (pc_plus1_o),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o)
`ifdef PC_FETCH_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o  (bubble_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline described as "booting", "waiting on a stalled word", or running
  logic        m_known = 1'b0;
  logic        m_boot, m_waiting;
  logic [7:0]  m_pc, m_ifpc, m_bub;
  logic        m_valid;
  logic [15:0] m_instr, m_skid;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1; m_boot = 1'b1; m_waiting = 1'b0;
      m_pc = 8'h00; m_valid = 1'b0; m_instr = NOP; m_ifpc = 8'h00;
      m_skid = NOP; m_bub = 8'h00;
    end else if (m_known) begin
      if (flush_i) begin
        m_pc = pc_next_i; m_valid = 1'b0; m_instr = NOP; m_ifpc = 8'h00;
        m_boot = 1'b0; m_waiting = 1'b0; m_skid = NOP;
        if (m_bub != 8'hFF) m_bub = m_bub + 8'd1;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_waiting) begin
        if (!stall_i) begin
          m_valid = 1'b1; m_instr = m_skid; m_ifpc = m_pc;
          m_pc = pc_next_i; m_waiting = 1'b0;
        end
      end else if (imem_ready_i) begin
        if (stall_i) begin
          m_skid = imem_rdata_i; m_waiting = 1'b1;
        end else begin
          m_valid = 1'b1; m_instr = imem_rdata_i; m_ifpc = m_pc; m_pc = pc_next_i;
        end
      end else if (!stall_i) begin
        m_valid = 1'b0; m_instr = NOP;
        if (m_bub != 8'hFF) m_bub = m_bub + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_pc",      {24'h0, pc_o},          {24'h0, m_pc});
      chk("m_addr",    {24'h0, imem_addr_o},   {24'h0, m_pc});
      chk("m_plus1",   {24'h0, pc_plus1_o},    {24'h0, 8'(m_pc + 8'd1)});
      chk("m_req",     {31'h0, imem_req_o},    {31'h0, !m_boot && !m_waiting});
      chk("m_valid",   {31'h0, if_id_valid_o}, {31'h0, m_valid});
      chk("m_instr",   {16'h0, if_id_instr_o}, {16'h0, m_instr});
      chk("m_ifpc",    {24'h0, if_id_pc_o},    {24'h0, m_ifpc});
`ifdef PC_FETCH_BUBBLE_CNT_EN
      chk("m_bubcnt",  {24'h0, bubble_cnt_o},  {24'h0, m_bub});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g;
    logic [15:0] skid_val;
`ifdef PC_FETCH_BUBBLE_CNT_EN
    logic [7:0] bub0;
`endif
    rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1;
    follow = 1'b1; pc_ovr = 8'h00;
    step(); step();
    chk("rst_pc",    {24'h0, pc_o}, 32'h00);
    chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid_o}, 32'h0);

    // Straight-line fetch
    rst_n = 1'b1;
    step();
    chk("boot_req",  {31'h0, imem_req_o}, 32'h1);
    chk("boot_valid",{31'h0, if_id_valid_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_instr", {16'h0, if_id_instr_o}, 32'hA000 + i);
      chk("seq_pc",    {24'h0, if_id_pc_o}, i);
      chk("seq_valid", {31'h0, if_id_valid_o}, 32'h1);
    end
    step(); step();
    chk("pc_at_5", {24'h0, pc_o}, 32'h05);

    // Stall while memory ready
    stall_i = 1'b1;
    step();
    chk("hold_req", {31'h0, imem_req_o}, 32'h0);
    step(); step();
    chk("hold_frz", {16'h0, if_id_instr_o}, 32'hA004);
    stall_i = 1'b0;
    step();
    chk("rel_instr", {16'h0, if_id_instr_o}, 32'hA005);
    chk("rel_pc",    {24'h0, if_id_pc_o}, 32'h05);
    chk("rel_pco",   {24'h0, pc_o}, 32'h06);

    // Flush with stall at 0x10
    g = 0;
    while (pc_o != 8'h10 && g < 40) begin step(); g++; end
    chk("reach_10", {24'h0, pc_o}, 32'h10);
    flush_i = 1'b1; stall_i = 1'b1; follow = 1'b0; pc_ovr = 8'h40;
    step();
    chk("fl_valid", {31'h0, if_id_valid_o}, 32'h0);
    chk("fl_instr", {16'h0, if_id_instr_o}, 32'h0);
    chk("fl_pc",    {24'h0, pc_o}, 32'h40);
    chk("fl_req",   {31'h0, imem_req_o}, 32'h1);
    flush_i = 1'b0; stall_i = 1'b0; follow = 1'b1;

    // Wait states at 0x20
    flush_i = 1'b1; follow = 1'b0; pc_ovr = 8'h1E;
    step();
    flush_i = 1'b0; follow = 1'b1;
    step(); step();
    chk("ws_pc0", {24'h0, pc_o}, 32'h20);
`ifdef PC_FETCH_BUBBLE_CNT_EN
    bub0 = bubble_cnt_o;
`endif
    imem_ready_i = 1'b0;
    step(); step();
    chk("ws_pc",    {24'h0, pc_o}, 32'h20);
    chk("ws_ifpc",  {24'h0, if_id_pc_o}, 32'h1F);
    chk("ws_valid", {31'h0, if_id_valid_o}, 32'h0);
`ifdef PC_FETCH_BUBBLE_CNT_EN
    chk("ws_bub", {24'h0, bubble_cnt_o}, {24'h0, 8'(bub0 + 8'd2)});
`endif
    stall_i = 1'b1;
    step();
    chk("ws_hold_pc", {24'h0, pc_o}, 32'h20);
    stall_i = 1'b0; imem_ready_i = 1'b1;
    step();
    chk("ws_resume", {16'h0, if_id_instr_o}, 32'hA020);

    // Wrap-around
    flush_i = 1'b1; follow = 1'b0; pc_ovr = 8'hFE;
    step();
    flush_i = 1'b0; follow = 1'b1;
    step();
    chk("wr_pc",    {24'h0, pc_o}, 32'hFF);
    chk("wr_plus1", {24'h0, pc_plus1_o}, 32'h00);
    step();
    chk("wr_ifpc",  {24'h0, if_id_pc_o}, 32'hFF);
    chk("wr_instr", {16'h0, if_id_instr_o}, 32'hA0FF);
    chk("wr_next",  {24'h0, pc_o}, 32'h00);

    // Reset in the middle of HOLD
    step(); step();
    skid_val = 16'hA000 + {8'h00, pc_o};
    stall_i = 1'b1;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("rh_pc",    {24'h0, pc_o}, 32'h00);
    chk("rh_valid", {31'h0, if_id_valid_o}, 32'h0);
    rst_n = 1'b1; stall_i = 1'b0;
    step();
    chk("rh_noskid0", {31'h0, if_id_instr_o == skid_val}, 32'h0);
    step();
    chk("rh_noskid1", {31'h0, if_id_instr_o == skid_val}, 32'h0);
    chk("rh_first",   {16'h0, if_id_instr_o}, 32'hA000);

    // Flush while in HOLD discards the skid
    stall_i = 1'b1;
    step();
    flush_i = 1'b1; stall_i = 1'b0; follow = 1'b0; pc_ovr = 8'h55;
    step();
    chk("hf_valid", {31'h0, if_id_valid_o}, 32'h0);
    flush_i = 1'b0; follow = 1'b1;
    step();
    chk("hf_instr", {16'h0, if_id_instr_o}, 32'hA055);

    // Flush during BOOT
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; flush_i = 1'b1; follow = 1'b0; pc_ovr = 8'h80;
    step();
    chk("bf_pc",  {24'h0, pc_o}, 32'h80);
    chk("bf_req", {31'h0, imem_req_o}, 32'h1);
    flush_i = 1'b0; follow = 1'b1;
    step();
    chk("bf_instr", {16'h0, if_id_instr_o}, 32'hA080);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
